// File: rtl/pipelined_instruction_memory.sv
// Instruction store for the pipelined MIPS core: registered fetch port with stall/flush,
// fault detection, a NOP-fill sequencer after reset and a program-load write port.
module pipelined_instruction_memory #(
    parameter int                 DATA_W    = 32,
    parameter int                 DEPTH     = 1024,
    parameter int                 ADDR_W    = 32,
    parameter bit                 BYTE_ADDR = 1'b1,
    parameter logic [DATA_W-1:0]  NOP       = '0,
    localparam int                IDX_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] address,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic              fault,
    output logic              busy,
    input  logic              load_en,
    input  logic [IDX_W-1:0]  load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam int SHIFT    = BYTE_ADDR ? 2 : 0;
    localparam int HI_SHIFT = IDX_W + SHIFT;

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [IDX_W-1:0]  fetch_idx;
    logic              misaligned;
    logic              out_of_range;
    logic              fetch_ok;

    assign fetch_idx    = IDX_W'(address >> SHIFT);
    assign misaligned   = BYTE_ADDR && (address[1:0] != 2'b00);
    assign out_of_range = |(address >> HI_SHIFT);
    assign fetch_ok     = (state_q == RUN) && fetch_req && !stall && !flush;

    // Sequencer and the single array write port, shared by clear and load.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        mem_we    = 1'b0;
        mem_waddr = load_addr;
        mem_wdata = load_data;
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_idx_q;
                mem_wdata = NOP;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end else if (load_en) begin
                mem_we = 1'b1;
            end
        end
    end

    // Output register: flush beats stall beats a new fetch.
    always_comb begin
        instr_d = instr_q;
        valid_d = valid_q;
        fault_d = fault_q;
        if (flush) begin
            instr_d = NOP;
            valid_d = 1'b0;
            fault_d = 1'b0;
        end else if (stall) begin
            instr_d = instr_q;
        end else if (fetch_ok) begin
            valid_d = 1'b1;
            if (misaligned || out_of_range) begin
                instr_d = NOP;
                fault_d = 1'b1;
            end else begin
                instr_d = mem_q[fetch_idx];
                fault_d = 1'b0;
            end
        end else begin
            instr_d = NOP;
            valid_d = 1'b0;
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            instr_q   <= NOP;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
        end
    end

    // Array is read combinationally before this write lands, giving read-before-write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign fault       = fault_q;
    assign busy        = (state_q == CLEAR);
    assign load_ready  = (state_q == RUN) && !rst;

endmodule

// File: tb/tb_pipelined_instruction_memory.sv
// Bench for pipelined_instruction_memory: directed vector table, clear/reset sequences,
// and a randomized run checked against an array-based reference model.
module tb_pipelined_instruction_memory;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-addressed instance
    logic        rst, fetch_req, stall, flush, load_en;
    logic [31:0] address, load_data, instruction;
    logic [3:0]  load_addr;
    logic        instr_valid, fault, busy, load_ready;

    // Word-addressed instance
    logic        rst_w, fetch_req_w, stall_w, flush_w, load_en_w;
    logic [31:0] address_w, load_data_w, instruction_w;
    logic [3:0]  load_addr_w;
    logic        instr_valid_w, fault_w, busy_w, load_ready_w;

    pipelined_instruction_memory #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .BYTE_ADDR(1'b1)) u_dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .address(address), .stall(stall),
        .flush(flush), .instruction(instruction), .instr_valid(instr_valid), .fault(fault),
        .busy(busy), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .load_ready(load_ready)
    );

    pipelined_instruction_memory #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .BYTE_ADDR(1'b0)) u_dut_w (
        .clk(clk), .rst(rst_w), .fetch_req(fetch_req_w), .address(address_w), .stall(stall_w),
        .flush(flush_w), .instruction(instruction_w), .instr_valid(instr_valid_w), .fault(fault_w),
        .busy(busy_w), .load_en(load_en_w), .load_addr(load_addr_w), .load_data(load_data_w),
        .load_ready(load_ready_w)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        fr;
        logic [31:0] addr;
        logic        st;
        logic        fl;
        logic        le;
        logic [3:0]  la;
        logic [31:0] ld;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];

    // Reference model: word array plus the three output values
    logic [31:0] mem_m [DEPTH];
    logic [31:0] m_instr;
    logic        m_valid, m_fault;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_req = 1'b0; address = '0; stall = 1'b0; flush = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    function automatic vec_t mkv(input logic fr, input logic [31:0] addr, input logic st,
                                 input logic fl, input logic le, input logic [3:0] la,
                                 input logic [31:0] ld, input logic [31:0] ei,
                                 input logic ev, input logic ef);
        vec_t v;
        v.fr = fr; v.addr = addr; v.st = st; v.fl = fl; v.le = le; v.la = la; v.ld = ld;
        v.e_instr = ei; v.e_valid = ev; v.e_fault = ef;
        return v;
    endfunction

    // Expected result of one cycle, evaluated on the inputs currently driven (RUN state).
    task automatic model_step();
        bit bad;
        bad = (address % 4 != 0) || (address / 4 >= DEPTH);
        if (flush) begin
            m_instr = '0; m_valid = 1'b0; m_fault = 1'b0;
        end else if (stall) begin
            m_instr = m_instr;
        end else if (fetch_req) begin
            m_valid = 1'b1;
            m_fault = bad;
            m_instr = bad ? 32'h0 : mem_m[int'(address / 4)];
        end else begin
            m_instr = '0; m_valid = 1'b0; m_fault = 1'b0;
        end
        if (load_en) mem_m[load_addr] = load_data;
    endtask

    task automatic count_clear(input string name, input bit chk_ready);
        int n;
        n = 0;
        while (busy && n < 100) begin
            if (chk_ready) check({name, "_load_ready_low"}, 32'(load_ready), 32'd0);
            tick();
            n++;
        end
        check({name, "_cycles"}, n, DEPTH);
    endtask

    initial begin
        idle();
        rst_w = 1'b1; fetch_req_w = 1'b0; address_w = '0; stall_w = 1'b0; flush_w = 1'b0;
        load_en_w = 1'b0; load_addr_w = '0; load_data_w = '0;
        rst = 1'b1;
        tick();
        check("rst_instr", instruction, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_w_busy", 32'(busy_w), 32'd1);
        rst = 1'b0; rst_w = 1'b0;
        count_clear("clear0", 1'b0);

        // Preload word 5, then reset: the clear must wipe it
        load_en = 1'b1; load_addr = 4'd5; load_data = 32'hDEADBEEF;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("clear1_busy_start", 32'(busy), 32'd1);
        count_clear("clear1", 1'b1);
        check("clear1_load_ready_up", 32'(load_ready), 32'd1);
        model_clear();
        fetch_req = 1'b1; address = 32'h14;
        tick();
        check("post_clear_instr", instruction, 32'h0);
        check("post_clear_valid", 32'(instr_valid), 32'd1);
        idle();
        tick();

        vecs.push_back(mkv(0, 32'h0,  0, 0, 1, 4'd0, 32'h8C0A0020, 32'h0,        0, 0));
        vecs.push_back(mkv(0, 32'h0,  0, 0, 1, 4'd1, 32'h8C0A0021, 32'h0,        0, 0));
        vecs.push_back(mkv(1, 32'h0,  0, 0, 0, 4'd0, 32'h0,        32'h8C0A0020, 1, 0));
        vecs.push_back(mkv(1, 32'h4,  0, 0, 0, 4'd0, 32'h0,        32'h8C0A0021, 1, 0));
        vecs.push_back(mkv(1, 32'h2,  0, 0, 0, 4'd0, 32'h0,        32'h0,        1, 1));
        vecs.push_back(mkv(1, 32'h40, 0, 0, 0, 4'd0, 32'h0,        32'h0,        1, 1));
        vecs.push_back(mkv(1, 32'h0,  0, 0, 0, 4'd0, 32'h0,        32'h8C0A0020, 1, 0));
        vecs.push_back(mkv(1, 32'h4,  1, 0, 0, 4'd0, 32'h0,        32'h8C0A0020, 1, 0));
        vecs.push_back(mkv(1, 32'h8,  1, 0, 0, 4'd0, 32'h0,        32'h8C0A0020, 1, 0));
        vecs.push_back(mkv(1, 32'h2,  1, 0, 0, 4'd0, 32'h0,        32'h8C0A0020, 1, 0));
        vecs.push_back(mkv(1, 32'h4,  1, 1, 0, 4'd0, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mkv(0, 32'h0,  0, 0, 1, 4'd2, 32'h7,        32'h0,        0, 0));
        vecs.push_back(mkv(1, 32'h8,  0, 0, 1, 4'd2, 32'h1,        32'h7,        1, 0));
        vecs.push_back(mkv(1, 32'h8,  0, 0, 0, 4'd0, 32'h0,        32'h1,        1, 0));
        vecs.push_back(mkv(0, 32'h0,  0, 0, 0, 4'd0, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mkv(1, 32'h3C, 0, 0, 0, 4'd0, 32'h0,        32'h0,        1, 0));
        vecs.push_back(mkv(1, 32'h3D, 0, 0, 0, 4'd0, 32'h0,        32'h0,        1, 1));
        vecs.push_back(mkv(1, 32'h4,  0, 1, 0, 4'd0, 32'h0,        32'h0,        0, 0));

        foreach (vecs[i]) begin
            fetch_req = vecs[i].fr; address = vecs[i].addr; stall = vecs[i].st;
            flush = vecs[i].fl; load_en = vecs[i].le; load_addr = vecs[i].la;
            load_data = vecs[i].ld;
            if (load_en) mem_m[load_addr] = load_data;
            tick();
            check($sformatf("vec%0d_instr", i), instruction, vecs[i].e_instr);
            check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d_fault", i), 32'(fault), 32'(vecs[i].e_fault));
            m_instr = vecs[i].e_instr; m_valid = vecs[i].e_valid; m_fault = vecs[i].e_fault;
        end

        for (int c = 0; c < 400; c++) begin
            fetch_req = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0, 1:    address = 32'($urandom_range(0, DEPTH - 1) * 4);
                2:       address = 32'($urandom_range(0, 127));
                default: address = $urandom;
            endcase
            stall     = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            load_en   = ($urandom_range(0, 2) == 0);
            load_addr = 4'($urandom_range(0, DEPTH - 1));
            load_data = $urandom;
            model_step();
            tick();
            check($sformatf("rnd%0d_instr", c), instruction, m_instr);
            check($sformatf("rnd%0d_valid", c), 32'(instr_valid), 32'(m_valid));
            check($sformatf("rnd%0d_fault", c), 32'(fault), 32'(m_fault));
            check($sformatf("rnd%0d_busy", c), 32'(busy), 32'd0);
        end

        // Reset mid-clear, with a load attempt that must be dropped
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (c == 3) begin
                load_en = 1'b1; load_addr = 4'd9; load_data = 32'h00001234;
                check("midclear_load_ready", 32'(load_ready), 32'd0);
            end else begin
                load_en = 1'b0;
            end
            tick();
        end
        idle();
        check("midclear_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("restart_busy", 32'(busy), 32'd1);
        count_clear("restart", 1'b1);
        fetch_req = 1'b1; address = 32'h24;
        tick();
        check("dropped_load_instr", instruction, 32'h0);
        check("dropped_load_valid", 32'(instr_valid), 32'd1);
        address = 32'h0;
        tick();
        check("recleared_word0", instruction, 32'h0);
        idle();
        tick();

        // Word-addressed instance
        check("w_busy", 32'(busy_w), 32'd0);
        load_en_w = 1'b1; load_addr_w = 4'd3; load_data_w = 32'hABCD0003;
        tick();
        load_en_w = 1'b0;
        fetch_req_w = 1'b1; address_w = 32'd3;
        tick();
        check("w_idx3_instr", instruction_w, 32'hABCD0003);
        check("w_idx3_fault", 32'(fault_w), 32'd0);
        address_w = 32'd16;
        tick();
        check("w_oor_fault", 32'(fault_w), 32'd1);
        check("w_oor_valid", 32'(instr_valid_w), 32'd1);
        address_w = 32'd2;
        tick();
        check("w_idx2_fault", 32'(fault_w), 32'd0);
        check("w_idx2_instr", instruction_w, 32'h0);
        fetch_req_w = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_instruction_memory.md
# pipelined_instruction_memory

Parametrised instruction memory for the 32-bit pipelined MIPS core. It replaces a fixed 1K-word, combinationally read store with a configurable-depth array that has a registered (1-cycle) fetch port with stall/flush, byte- or word-addressing, and fault detection. A self-clearing reset sequencer fills the array with NOP over DEPTH cycles, and a program-load write port lets the testbench or boot logic install code after reset. It sits between the PC register and the IF/ID pipeline register.

## Interface
- DATA_W, 32: instruction width in bits.
- DEPTH, 1024: number of words; power of two, at least 2. IDX_W = log2(DEPTH).
- ADDR_W, 32: fetch address width.
- BYTE_ADDR, 1: 1 = address is a byte address (word index = address[IDX_W+1:2]); 0 = address is a word index (address[IDX_W-1:0]).
- NOP, {DATA_W{1'b0}}: clear value and bubble value.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- fetch_req  in  1  fetch request for `address`.
- address  in  ADDR_W  PC.
- stall  in  1  hold the output registers.
- flush  in  1  squash the output (insert a bubble).
- instruction  out  DATA_W  registered fetched word.
- instr_valid  out  1  `instruction` holds a fetch result.
- fault  out  1  the registered fetch was misaligned or out of range.
- busy  out  1  clear sequence in progress.
- load_en  in  1  write load_data at load_addr.
- load_addr  in  IDX_W  word index for the write.
- load_data  in  DATA_W  word to write.
- load_ready  out  1  load writes are accepted this cycle.

## Operation
- FSM states:
  - CLEAR: a counter clr_idx walks from 0 to DEPTH-1, writing NOP to one word per cycle.
  - RUN: normal operation.
- FSM transitions:
  - rst forces CLEAR with clr_idx=0 from any state, including mid-CLEAR; the sequence restarts.
  - CLEAR goes to RUN on the cycle that writes index DEPTH-1.
- busy = (state==CLEAR). load_ready = (state==RUN) && !rst.
- Load port:
  - load_en with load_ready writes the array at the clock edge.
  - load_en while not ready is ignored and dropped, not queued.
- Fetch acceptance: a fetch is accepted when state==RUN, fetch_req=1, stall=0 and flush=0.
- Fault detection:
  - Misaligned: BYTE_ADDR=1 and address[1:0]!=0.
  - Out of range: any address bit above the index field is nonzero.
  - A faulting fetch registers instruction=NOP, fault=1, instr_valid=1. No array read is used.
- Output register priority, highest first:
  1. rst: NOP / 0 / 0.
  2. flush: NOP / 0 / 0.
  3. stall: hold all three outputs.
  4. Accepted fetch: result / 0 or 1 / 1.
  5. Otherwise (CLEAR, or no request): NOP / 0 / 0.
- Same-cycle fetch and load to the same index: the fetch returns the old contents (read-before-write). The new word is visible from the next fetch onward.
- flush and stall together: flush wins.

## Timing
- Reset values, on the edge after rst=1: instruction=NOP, instr_valid=0, fault=0, busy=1, load_ready=0.
- CLEAR occupies exactly DEPTH cycles after rst deasserts. busy falls on the edge that writes index DEPTH-1; load_ready rises in the same cycle.
- Fetch latency is 1 cycle: a request accepted at edge N has its result visible after edge N, valid through edge N+1 unless the outputs are stalled.
- Throughput: one fetch per cycle and one load write per cycle, concurrently.
- stall holds the outputs indefinitely; requests made while stalled are not recorded.

## Test plan
- Reset/clear: preload word 5 via load, assert rst for 1 cycle, run DEPTH=16 → busy=1 for exactly 16 cycles, load_ready=0 during clear; the subsequent fetch of byte address 0x14 → instruction=0x00000000, instr_valid=1.
- Load/fetch, BYTE_ADDR=1:
  - Load index 0=0x8C0A0020 and index 1=0x8C0A0021, then fetch 0x0 and 0x4 back-to-back → those words on consecutive cycles, fault=0.
  - Fetch 0x2 → fault=1, NOP.
  - Fetch 0x40 with DEPTH=16 → fault=1.
- Stall/flush:
  - Fetch 0x0 then stall for 3 cycles while the address changes → output holds 0x8C0A0020, valid=1.
  - flush+stall together → next cycle valid=0, instruction=NOP.
- Read-before-write: load index 2=0x1 and fetch 0x8 in the same cycle, where index 2 previously held 0x7 → first fetch returns 0x7, repeat fetch returns 0x1.
- Reset mid-clear: assert rst at clear cycle 7 → busy stays 1 and clear restarts, lasting 16 more cycles. A load attempted mid-clear is dropped and the word reads NOP afterwards.
- BYTE_ADDR=0: fetch address 3 → word at index 3. Fetch address 16 with DEPTH=16 → fault=1.
